// File: rtl/bruteforce_search_unit_pkg.sv
// Shared definitions for the brute-force search unit: default alphabet size,
// default maximum candidate length, ASCII code of the first alphabet
// character and the search state machine encoding.
package bruteforce_search_unit_pkg;

  localparam int         CHARSET_LEN = 26;
  localparam int         MAX_CHARS   = 16;
  localparam logic [7:0] ASCII_BASE  = 8'h61;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_INIT,
    ST_RUN,
    ST_FOUND,
    ST_EXHAUSTED
  } state_t;

endpackage

// File: rtl/bruteforce_search_unit_candidate_gen.sv
// Candidate generator: holds the current candidate as a bijective base-N
// digit array (digit 0 is the last character) and advances it by a small
// step with a full single-cycle carry ripple.
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   advance, step     apply "candidate += step" on this edge (step >= 1)
//   guess             rendered string, first character in bits [127:120]
//   num_chars         current length in characters
//   overflow          the advance requested now would carry out of the top digit
module candidate_gen #(
  parameter int CHARSET_LEN = bruteforce_search_unit_pkg::CHARSET_LEN,
  parameter int MAX_CHARS   = bruteforce_search_unit_pkg::MAX_CHARS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  input  logic [2:0]   step,
  output logic [127:0] guess,
  output logic [7:0]   num_chars,
  output logic         overflow
);
  import bruteforce_search_unit_pkg::*;

  localparam int DIGIT_W = $clog2(CHARSET_LEN);

  logic [DIGIT_W-1:0] digits     [MAX_CHARS];
  logic [DIGIT_W-1:0] digits_nxt [MAX_CHARS];
  logic [7:0]         len_nxt;

  // Digits above num_chars are always zero, so a carry into position
  // num_chars simply appends a new leading 'a'.
  always_comb begin : ripple
    int carry;
    int sum;
    carry   = int'(step);
    len_nxt = num_chars;
    for (int i = 0; i < MAX_CHARS; i++) begin
      digits_nxt[i] = digits[i];
      sum = int'(digits[i]) + carry;
      if (i < int'(num_chars)) begin
        if (sum >= CHARSET_LEN) begin
          digits_nxt[i] = DIGIT_W'(sum - CHARSET_LEN);
          carry = 1;
        end else begin
          digits_nxt[i] = DIGIT_W'(sum);
          carry = 0;
        end
      end else if (i == int'(num_chars) && carry != 0) begin
        digits_nxt[i] = '0;
        len_nxt = num_chars + 8'd1;
        carry = 0;
      end
    end
    overflow = (carry != 0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_CHARS; i++) digits[i] <= '0;
      num_chars <= 8'd1;
    end else if (advance && !overflow) begin
      digits    <= digits_nxt;
      num_chars <= len_nxt;
    end
  end

  // Digit i lands at character position num_chars-1-i, left-aligned.
  always_comb begin : render
    logic [6:0] lo;
    lo    = '0;
    guess = '0;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (i < int'(num_chars)) begin
        lo = 7'(128 - 8 * int'(num_chars) + 8 * i);
        guess[lo +: 8] = ASCII_BASE + 8'(digits[i]);
      end
    end
  end

endmodule

// File: rtl/bruteforce_search_unit.sv
// Brute-force search unit: enumerates lowercase candidates, hands them one at
// a time to an external hash core and compares each returned digest with the
// target. Stops on a match (FOUND) or when the candidate space is used up
// (EXHAUSTED).
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   start_pos, increment         index offset and stride, sampled at HOLD exit
//   target_hash                  digest being searched for
//   hash_in, hash_valid          digest of the in-flight candidate
//   guess, num_chars,
//   guess_valid, guess_take      candidate handshake
//   enable                       search active
//   equal_valid, hashes_equal    comparison pulse and sticky match flag
//   plaintext                    candidate that matched
//   exhausted                    sticky end-of-space flag
module bruteforce_search_unit #(
  parameter int CHARSET_LEN = bruteforce_search_unit_pkg::CHARSET_LEN,
  parameter int MAX_CHARS   = bruteforce_search_unit_pkg::MAX_CHARS,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   start_pos,
  input  logic [2:0]   increment,
  input  logic [127:0] target_hash,
  input  logic [127:0] hash_in,
  input  logic         hash_valid,
  input  logic         guess_take,
  output logic         enable,
  output logic [127:0] guess,
  output logic [7:0]   num_chars,
  output logic         guess_valid,
  output logic         equal_valid,
  output logic         hashes_equal,
  output logic [127:0] plaintext,
  output logic         exhausted
);
  import bruteforce_search_unit_pkg::*;

  state_t       state, state_nxt;
  logic [7:0]   hold_cnt;
  logic [7:0]   init_cnt;
  logic [7:0]   start_pos_q;
  logic [2:0]   stride_q;
  logic         in_flight;
  logic [127:0] flight_guess;
  logic         gen_advance;
  logic [2:0]   gen_step;
  logic         gen_overflow;
  logic         take_accept;
  logic         hash_accept;
  logic         hash_match;

  assign hash_match = (hash_in == target_hash);

  candidate_gen #(
    .CHARSET_LEN (CHARSET_LEN),
    .MAX_CHARS   (MAX_CHARS)
  ) u_gen (
    .clock     (clock),
    .reset     (reset),
    .advance   (gen_advance),
    .step      (gen_step),
    .guess     (guess),
    .num_chars (num_chars),
    .overflow  (gen_overflow)
  );

  // A returning hash always wins over a new take: guess_valid is low while a
  // candidate is in flight, so the take can only be accepted on a later cycle.
  always_comb begin
    state_nxt   = state;
    gen_advance = 1'b0;
    gen_step    = stride_q;
    take_accept = 1'b0;
    hash_accept = 1'b0;
    enable      = 1'b0;
    guess_valid = 1'b0;
    case (state)
      ST_HOLD: begin
        if (int'(hold_cnt) + 1 >= HOLD_CYCLES) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        gen_step = 3'd1;
        if (init_cnt == start_pos_q) begin
          state_nxt = ST_RUN;
        end else begin
          gen_advance = 1'b1;
          if (gen_overflow) state_nxt = ST_EXHAUSTED;
        end
      end
      ST_RUN: begin
        enable      = 1'b1;
        guess_valid = !in_flight;
        if (hash_valid && in_flight) begin
          hash_accept = 1'b1;
          if (hash_match) state_nxt = ST_FOUND;
        end else if (guess_take && !in_flight) begin
          take_accept = 1'b1;
          gen_advance = 1'b1;
          if (gen_overflow) state_nxt = ST_EXHAUSTED;
        end
      end
      ST_EXHAUSTED: begin
        // Stay enabled only until the last candidate's hash has come back.
        enable = in_flight;
        if (hash_valid && in_flight) hash_accept = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= 8'd0;
      init_cnt     <= 8'd0;
      start_pos_q  <= 8'd0;
      stride_q     <= 3'd1;
      in_flight    <= 1'b0;
      equal_valid  <= 1'b0;
      hashes_equal <= 1'b0;
      exhausted    <= 1'b0;
      plaintext    <= '0;
    end else begin
      state       <= state_nxt;
      equal_valid <= hash_accept;
      if (state == ST_HOLD) begin
        hold_cnt <= hold_cnt + 8'd1;
        if (state_nxt == ST_INIT) begin
          start_pos_q <= start_pos;
          stride_q    <= (increment == 3'd0) ? 3'd1 : increment;
        end
      end
      if (state == ST_INIT && gen_advance) init_cnt <= init_cnt + 8'd1;
      if (take_accept)      in_flight <= 1'b1;
      else if (hash_accept) in_flight <= 1'b0;
      if (hash_accept) begin
        hashes_equal <= hash_match;
        if (hash_match) plaintext <= flight_guess;
      end
      if (state_nxt == ST_EXHAUSTED) exhausted <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (take_accept) flight_guess <= guess;
  end

endmodule

// File: tb/tb_bruteforce_search_unit.sv
// Self-checking bench for bruteforce_search_unit. Two instances share the
// stimulus: the default one (MAX_CHARS=16) and a short one (MAX_CHARS=2)
// used for the exhaustion case.
module tb_bruteforce_search_unit;

  localparam logic [127:0] MD5_A = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] MD5_B = 128'h92eb5ffee6ae2fec3ad71c777531578f;
  localparam logic [127:0] MD5_C = 128'h4a8a08f09d37b73795649038408b5f33;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic [7:0]   start_pos;
  logic [2:0]   increment;
  logic [127:0] target_hash, hash_in;
  logic         hash_valid, guess_take;

  logic         enable, guess_valid, equal_valid, hashes_equal, exhausted;
  logic [127:0] guess, plaintext;
  logic [7:0]   num_chars;

  logic         enable_b, guess_valid_b, equal_valid_b, hashes_equal_b, exhausted_b;
  logic [127:0] guess_b, plaintext_b;
  logic [7:0]   num_chars_b;

  int checks = 0;
  int errors = 0;

  bruteforce_search_unit #(.HOLD_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start_pos(start_pos), .increment(increment),
    .target_hash(target_hash), .hash_in(hash_in), .hash_valid(hash_valid),
    .guess_take(guess_take), .enable(enable), .guess(guess), .num_chars(num_chars),
    .guess_valid(guess_valid), .equal_valid(equal_valid), .hashes_equal(hashes_equal),
    .plaintext(plaintext), .exhausted(exhausted)
  );

  bruteforce_search_unit #(.MAX_CHARS(2), .HOLD_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .start_pos(start_pos), .increment(increment),
    .target_hash(target_hash), .hash_in(hash_in), .hash_valid(hash_valid),
    .guess_take(guess_take), .enable(enable_b), .guess(guess_b), .num_chars(num_chars_b),
    .guess_valid(guess_valid_b), .equal_valid(equal_valid_b), .hashes_equal(hashes_equal_b),
    .plaintext(plaintext_b), .exhausted(exhausted_b)
  );

  // Reference: candidate index n (0 = "a") is the bijective base-26 numeral of n+1.
  function automatic logic [127:0] model_guess(input longint n);
    longint v;
    logic [127:0] g;
    int k;
    v = n + 1;
    g = '0;
    k = 0;
    while (v > 0) begin
      v = v - 1;
      g = g | ({120'd0, 8'(64'h61 + v % 26)} << (8 * k));
      v = v / 26;
      k++;
    end
    return g << (8 * (16 - k));
  endfunction

  function automatic logic [7:0] model_len(input longint n);
    longint v;
    int k;
    v = n + 1;
    k = 0;
    while (v > 0) begin
      v = (v - 1) / 26;
      k++;
    end
    return 8'(k);
  endfunction

  function automatic logic [127:0] md5_of(input logic [127:0] g);
    case (g)
      {"a", 120'd0}: return MD5_A;
      {"b", 120'd0}: return MD5_B;
      {"c", 120'd0}: return MD5_C;
      default:       return '1;
    endcase
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [7:0] sp, input logic [2:0] inc);
    reset = 1'b0;
    guess_take = 1'b0;
    hash_valid = 1'b0;
    start_pos = sp;
    increment = inc;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic wait_gv(input string name);
    int n;
    n = 0;
    while (!guess_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!guess_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: guess_valid got 0 expected 1 within 400 cycles", name);
    end
  endtask

  task automatic take_one(output logic [127:0] g, output logic [7:0] nc);
    wait_gv("take_wait");
    g = guess;
    nc = num_chars;
    guess_take = 1'b1;
    @(negedge clock);
    guess_take = 1'b0;
  endtask

  task automatic reply(input logic [127:0] h);
    hash_in = h;
    hash_valid = 1'b1;
    @(negedge clock);
    hash_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]   sp;
    logic [2:0]   inc;
    int           k;
    logic [127:0] exp_guess;
    logic [7:0]   exp_len;
  } vec_t;

  vec_t vecs[12];
  logic [127:0] g;
  logic [7:0] nc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time got 1ms expected completion earlier");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'd0,   3'd1, 0,  {"a",  120'd0}, 8'd1};
    vecs[1]  = '{8'd0,   3'd1, 1,  {"b",  120'd0}, 8'd1};
    vecs[2]  = '{8'd0,   3'd1, 25, {"z",  120'd0}, 8'd1};
    vecs[3]  = '{8'd0,   3'd1, 26, {"aa", 112'd0}, 8'd2};
    vecs[4]  = '{8'd3,   3'd4, 0,  {"d",  120'd0}, 8'd1};
    vecs[5]  = '{8'd3,   3'd4, 1,  {"h",  120'd0}, 8'd1};
    vecs[6]  = '{8'd3,   3'd4, 2,  {"l",  120'd0}, 8'd1};
    vecs[7]  = '{8'd3,   3'd4, 5,  {"x",  120'd0}, 8'd1};
    vecs[8]  = '{8'd3,   3'd4, 6,  {"ab", 112'd0}, 8'd2};
    vecs[9]  = '{8'd0,   3'd0, 3,  {"d",  120'd0}, 8'd1};
    vecs[10] = '{8'd5,   3'd7, 4,  {"ah", 112'd0}, 8'd2};
    vecs[11] = '{8'd255, 3'd1, 0,  {"iv", 112'd0}, 8'd2};

    target_hash = rand128();
    hash_in = '0;

    // Reset values
    do_reset(8'd0, 3'd1);
    reset = 1'b0;
    check("rst_enable", enable, 0);
    check("rst_guess_valid", guess_valid, 0);
    check("rst_equal_valid", equal_valid, 0);
    check("rst_hashes_equal", hashes_equal, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_plaintext", plaintext, 0);
    check("rst_guess", guess, {"a", 120'd0});
    check("rst_num_chars", num_chars, 1);

    // Table of sequences: reach the k-th candidate, compare guess and length
    for (int i = 0; i < 12; i++) begin
      do_reset(vecs[i].sp, vecs[i].inc);
      for (int j = 0; j < vecs[i].k; j++) begin
        take_one(g, nc);
        reply(rand128());
        if (j == 0) begin
          check("mis_equal_valid", equal_valid, 1);
          check("mis_hashes_equal", hashes_equal, 0);
          check("mis_guess_valid_back", guess_valid, 1);
          @(negedge clock);
          check("mis_equal_pulse_end", equal_valid, 0);
        end
      end
      wait_gv("vec_wait");
      check($sformatf("vec%0d_guess", i), guess, vecs[i].exp_guess);
      check($sformatf("vec%0d_num_chars", i), num_chars, vecs[i].exp_len);
    end

    // Match on "c"
    target_hash = MD5_C;
    do_reset(8'd0, 3'd1);
    for (int j = 0; j < 3; j++) begin
      take_one(g, nc);
      check("md5_enable_before", enable, 1);
      reply(md5_of(g));
      check("md5_equal_valid", equal_valid, 1);
      check("md5_hashes_equal", hashes_equal, (j == 2) ? 1 : 0);
    end
    check("md5_enable_drop", enable, 0);
    check("md5_plaintext", plaintext, {"c", 120'd0});
    check("md5_guess_valid", guess_valid, 0);
    @(negedge clock);
    check("md5_pulse_end", equal_valid, 0);
    check("md5_sticky", hashes_equal, 1);
    reply(MD5_C);
    check("found_hash_ignored", equal_valid, 0);
    check("found_enable_low", enable, 0);

    // Asynchronous reset mid-run, then restart timing
    target_hash = rand128();
    do_reset(8'd2, 3'd1);
    for (int j = 0; j < 10; j++) begin
      take_one(g, nc);
      reply(rand128());
    end
    take_one(g, nc);
    #2;
    reset = 1'b0;
    #1;
    check("arst_enable", enable, 0);
    check("arst_guess_valid", guess_valid, 0);
    check("arst_equal_valid", equal_valid, 0);
    check("arst_hashes_equal", hashes_equal, 0);
    check("arst_exhausted", exhausted, 0);
    check("arst_plaintext", plaintext, 0);
    check("arst_guess", guess, {"a", 120'd0});
    check("arst_num_chars", num_chars, 1);
    @(negedge clock);
    reset = 1'b1;
    begin
      int c;
      c = 0;
      while (!enable && c < 50) begin
        @(negedge clock);
        c++;
        if (c == 4) begin
          start_pos = 8'd9;
          increment = 3'd5;
        end
      end
      check("restart_enable_cycles", 128'(c), 128'(4 + 2 + 1));
    end
    check("restart_guess", guess, {"c", 120'd0});
    take_one(g, nc);
    reply(rand128());
    check("restart_stride_sampled", guess, {"d", 120'd0});

    // Randomized runs against the reference model
    for (int t = 0; t < 6; t++) begin
      longint n;
      int eff;
      logic [7:0] sp;
      logic [2:0] inc;
      sp = 8'($urandom_range(0, 60));
      inc = 3'($urandom_range(0, 7));
      eff = (inc == 3'd0) ? 1 : int'(inc);
      target_hash = rand128();
      do_reset(sp, inc);
      n = longint'(sp);
      for (int j = 0; j < 30; j++) begin
        take_one(g, nc);
        check("rnd_guess", g, model_guess(n));
        check("rnd_num_chars", nc, model_len(n));
        n = n + eff;
        for (int d = 0; d < int'($urandom_range(0, 3)); d++) begin
          guess_take = 1'($urandom_range(0, 1));
          @(negedge clock);
          guess_take = 1'b0;
          check("rnd_inflight_gv", guess_valid, 0);
        end
        guess_take = 1'($urandom_range(0, 1));
        reply(rand128());
        guess_take = 1'b0;
        check("rnd_equal_valid", equal_valid, 1);
        if ($urandom_range(0, 3) == 0) begin
          reply(rand128());
          check("rnd_idle_hash_ignored", equal_valid, 0);
        end
      end
    end

    // Exhaustion of the two-character instance
    target_hash = rand128();
    do_reset(8'd0, 3'd1);
    for (int i = 0; i < 702; i++) begin
      wait_gv("exh_wait");
      check("exh_guess", guess_b, model_guess(longint'(i)));
      if (i == 701) begin
        check("exh_len_zz", num_chars_b, model_len(701));
        check("exh_not_yet", exhausted_b, 0);
        check("exh_gv_before", guess_valid_b, 1);
      end
      take_one(g, nc);
      if (i < 701) reply(rand128());
    end
    check("exh_flag", exhausted_b, 1);
    check("exh_enable_inflight", enable_b, 1);
    check("exh_gv_inflight", guess_valid_b, 0);
    reply(rand128());
    check("exh_last_equal_valid", equal_valid_b, 1);
    check("exh_enable_off", enable_b, 0);
    for (int i = 0; i < 3; i++) begin
      guess_take = 1'b1;
      @(negedge clock);
      guess_take = 1'b0;
      check("exh_gv_stays_low", guess_valid_b, 0);
      check("exh_sticky", exhausted_b, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bruteforce_search_unit.md
BRUTEFORCE_SEARCH_UNIT -- requirements
Module: bruteforce_search_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: `clock` (rising edge), `reset` (0 = reset asserted).
REQ-002 Parameter: CHARSET_LEN, default 26, the number of alphabet characters ('a'..'z', ASCII 0x61..0x7A).
REQ-003 Parameter: MAX_CHARS, default 16, the maximum candidate length (16 x 8 = 128 bits).
REQ-004 Parameter: HOLD_CYCLES, default 4, the number of cycles enable is held low after reset release.
REQ-005 Port: clock  in  1  system clock.
REQ-006 Port: reset  in  1  asynchronous active-low reset.
REQ-007 Port: start_pos  in  8  candidate index offset for this instance.
REQ-008 Port: increment  in  3  stride between candidates; 0 is treated as 1.
REQ-009 Port: target_hash  in  128  digest being searched for.
REQ-010 Port: hash_in  in  128  digest of the last taken candidate, from the external MD5 core.
REQ-011 Port: hash_valid  in  1  hash_in is valid this cycle.
REQ-012 Port: guess_take  in  1  consumer accepts the current guess.
REQ-013 Port: enable  out  1  search active.
REQ-014 Port: guess  out  128  candidate string: first character in bits [127:120], unused low bytes zero.
REQ-015 Port: num_chars  out  8  candidate length in characters, 1..16.
REQ-016 Port: guess_valid  out  1  guess/num_chars are valid and may be taken.
REQ-017 Port: equal_valid  out  1  one-cycle pulse marking a comparison result.
REQ-018 Port: hashes_equal  out  1  sticky match flag.
REQ-019 Port: plaintext  out  128  the candidate whose hash matched.
REQ-020 Port: exhausted  out  1  sticky flag: the search space ended without a match.

Function
REQ-021 State machine SHALL be HOLD -> INIT -> RUN -> {FOUND | EXHAUSTED}; FOUND and EXHAUSTED are terminal until reset.
REQ-022 HOLD SHALL count HOLD_CYCLES cycles with enable=0, then go to INIT.
REQ-023 INIT SHALL start from candidate "a" and apply single-step advances, one per cycle, start_pos times, with guess_valid=0; it then goes to RUN with enable=1.
REQ-024 A candidate SHALL be a bijective base-26 number: digits 0..25 map to 'a'..'z', digit 0 is the last character, and the length equals num_chars.
REQ-025 To advance by s, the block SHALL add s to digit 0; a sum of 26 or more subtracts 26 and carries 1 to the next digit, rippling through all digits in the same cycle.
REQ-026 A carry out of the top digit SHALL append a new leading digit 0 and increment num_chars (for example "z"+1 = "aa", "zz"+1 = "aaa").
REQ-027 In RUN, guess_valid SHALL be 1 while no candidate is in flight.
REQ-028 guess_valid && guess_take SHALL, in the same edge, latch guess into an in-flight register, set in-flight, and advance the candidate by increment (0 treated as 1).
REQ-029 While a candidate is in flight, guess_valid SHALL be 0 and guess_take SHALL be ignored.
REQ-030 hash_valid while enable=1 and in-flight SHALL register equal_valid=1 for one cycle, set hashes_equal=(hash_in==target_hash), and clear in-flight.
REQ-031 hash_valid SHALL be ignored when enable=0 or nothing is in flight.
REQ-032 On a match, the block SHALL load plaintext with the in-flight candidate, set hashes_equal=1 (sticky), drop enable to 0 on the same edge, and enter FOUND.
REQ-033 If an advance carries out of digit MAX_CHARS-1, the block SHALL set exhausted=1, enter EXHAUSTED, and drive guess_valid=0 and enable=0 once any in-flight result has returned.
REQ-034 start_pos and increment SHALL be sampled once, at HOLD exit; later changes have no effect until the next reset.
REQ-035 If guess_take and hash_valid occur in the same cycle, the hash SHALL be processed first and the new take SHALL be accepted only on a later cycle.

Reset
REQ-036 While reset=0, outputs SHALL be: enable=0, guess_valid=0, equal_valid=0, hashes_equal=0, exhausted=0, plaintext=0, guess = "a" (0x61 followed by zero bytes), num_chars=1, state=HOLD, in-flight cleared.
REQ-037 Reset asserted mid-operation (including in FOUND or EXHAUSTED) SHALL abort immediately and restart from HOLD after release.

Structure
REQ-038 A shared package SHALL hold CHARSET_LEN, MAX_CHARS, the ASCII base 0x61 and the state enumeration type.
REQ-039 The candidate generator (digit array, ripple increment, length) SHALL be one sub-module, candidate_gen; the hold counter, handshake, comparator and state machine stay in the top level.

Verification
REQ-040 Case 1: start_pos=0, increment=1, take every candidate -> guesses in order "a","b",..,"z","aa", with num_chars going 1 -> 2 at the 27th guess.
REQ-041 Case 2: start_pos=3, increment=4 -> first guesses "d","h","l"; after "z"-region wrap, "x"+4 = "ab".
REQ-042 Case 3: target_hash = MD5("c") = 4a8a08f09d37b73795649038408b5f33, with the bench returning the correct MD5 -> match on the third candidate; plaintext = "c"; hashes_equal=1; enable falls on the same edge as equal_valid.
REQ-043 Case 4: hash_valid with a mismatching digest -> equal_valid pulses for one cycle, hashes_equal stays 0, and guess_valid returns to 1 the next cycle.
REQ-044 Case 5: assert reset during RUN after 10 candidates -> all outputs return to reset values asynchronously; enable rises HOLD_CYCLES+start_pos+1 cycles after release.
REQ-045 Case 6: MAX_CHARS=2, increment=1, never match -> exhausted=1 after 702 candidates ("zz"), and guess_valid stays 0 afterwards.
